qspi_ram_bridge: RTL and testbench



---
 rtl/qspi_pkg.sv | 25 ++
 rtl/qspi_sync_edge.sv | 32 +++
 rtl/qspi_ram_bridge.sv | 169 ++++++++++++++++
 tb/tb_qspi_ram_bridge.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI-to-RAM bridge: command codes, FSM states
// and fixed protocol/RAM timing constants.
package qspi_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam int DUMMY_NIBBLES = 2;
  localparam int RAM_RD_LAT    = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    WDATA  = 3'd3,
    DUMMY  = 3'd4,
    RDATA  = 3'd5,
    IGNORE = 3'd6
  } state_t;

  function automatic logic cmd_known(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/qspi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with rise/fall detection on
// the synchronized value.
module qspi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Resetting to 0 means a pin already low never yields a false fall,
  // so a frame in progress at reset is ignored until the next real CS fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/qspi_ram_bridge.sv
// QSPI target giving a host byte-wide write (0x02) and read (0x0B) access to
// one port of the shared 8-bit RAM.
module qspi_ram_bridge
  import qspi_pkg::*;
#(
  parameter int addr_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  qspi_sck,
  input  logic                  qspi_cs_n,
  input  logic [3:0]            qspi_io_in,
  output logic [3:0]            qspi_io_out,
  output logic                  qspi_io_oe,
  output logic [addr_width-1:0] addr,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  wen
);

  localparam logic [addr_width-1:0] ADDR_ONE = {{(addr_width-1){1'b0}}, 1'b1};
  localparam logic [1:0] PF_LOAD    = 2'(RAM_RD_LAT + 1);
  localparam logic [1:0] DUMMY_LAST = 2'(DUMMY_NIBBLES - 1);

  logic w_sck_rise;
  logic w_sck_fall;
  logic w_cs_rise;
  logic w_cs_fall;
  logic [7:0] w_byte;
  logic w_last_nib;

  state_t                r_state;
  logic [1:0]            r_nib;
  logic [3:0]            r_rx_hi;
  logic                  r_is_read;
  logic [addr_width-1:0] r_addr;
  logic [7:0]            r_data_out;
  logic                  r_wen;
  logic [3:0]            r_io_out;
  logic                  r_oe;
  logic [3:0]            r_tx_lo;
  logic [7:0]            r_pf;
  logic [1:0]            r_pf_cnt;

  qspi_sync_edge u_sck_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (qspi_sck),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  qspi_sync_edge u_cs_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (qspi_cs_n),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  assign w_byte     = {r_rx_hi, qspi_io_in};
  assign w_last_nib = (r_state == DUMMY) ? (r_nib == DUMMY_LAST) : (r_nib == 2'd1);

  // Frame FSM, receive shifter, write strobe and read prefetch sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_nib      <= 2'd0;
      r_rx_hi    <= 4'h0;
      r_is_read  <= 1'b0;
      r_addr     <= '0;
      r_data_out <= 8'h00;
      r_wen      <= 1'b0;
      r_io_out   <= 4'h0;
      r_oe       <= 1'b0;
      r_tx_lo    <= 4'h0;
      r_pf       <= 8'h00;
      r_pf_cnt   <= 2'd0;
    end else begin
      r_wen <= 1'b0;
      // Post-write increment lands the cycle after the strobe.
      if (r_wen) begin
        r_addr <= r_addr + ADDR_ONE;
      end
      // Countdown to the cycle where data_in reflects the new address.
      if (r_pf_cnt != 2'd0) begin
        r_pf_cnt <= r_pf_cnt - 2'd1;
        if (r_pf_cnt == 2'd1) begin
          r_pf <= data_in;
        end
      end

      if (w_cs_rise) begin
        r_state  <= IDLE;
        r_nib    <= 2'd0;
        r_oe     <= 1'b0;
        r_io_out <= 4'h0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_cs_fall) begin
              r_state <= CMD;
              r_nib   <= 2'd0;
            end
          end
          CMD, ADDR, WDATA, DUMMY: begin
            if (w_sck_rise) begin
              r_rx_hi <= qspi_io_in;
              if (w_last_nib) begin
                r_nib <= 2'd0;
                case (r_state)
                  CMD: begin
                    if (cmd_known(w_byte)) begin
                      r_is_read <= (w_byte == CMD_READ);
                      r_state   <= ADDR;
                    end else begin
                      r_state <= IGNORE;
                    end
                  end
                  ADDR: begin
                    r_addr <= w_byte[addr_width-1:0];
                    if (r_is_read) begin
                      r_state  <= DUMMY;
                      r_pf_cnt <= PF_LOAD;
                    end else begin
                      r_state <= WDATA;
                    end
                  end
                  WDATA: begin
                    r_data_out <= w_byte;
                    r_wen      <= 1'b1;
                  end
                  DUMMY:   r_state <= RDATA;
                  default: r_state <= IDLE;
                endcase
              end else begin
                r_nib <= r_nib + 2'd1;
              end
            end
          end
          RDATA: begin
            if (w_sck_fall) begin
              if (r_nib == 2'd0) begin
                r_io_out <= r_pf[7:4];
                r_tx_lo  <= r_pf[3:0];
                r_addr   <= r_addr + ADDR_ONE;
                r_pf_cnt <= PF_LOAD;
                r_oe     <= 1'b1;
                r_nib    <= 2'd1;
              end else begin
                r_io_out <= r_tx_lo;
                r_nib    <= 2'd0;
              end
            end
          end
          IGNORE: r_state <= IGNORE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign qspi_io_out = r_io_out;
  assign qspi_io_oe  = r_oe;
  assign addr        = r_addr;
  assign data_out    = r_data_out;
  assign wen         = r_wen;

endmodule

// File: tb/tb_qspi_ram_bridge.sv
// Directed bench for qspi_ram_bridge: a QSPI host model plus a 2-cycle RAM.
module tb_qspi_ram_bridge;
  import qspi_pkg::*;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       qspi_sck = 1'b0;
  logic       qspi_cs_n = 1'b1;
  logic [3:0] qspi_io_in = 4'h0;
  logic [3:0] qspi_io_out;
  logic       qspi_io_oe;
  logic [7:0] addr;
  logic [7:0] ram_rdata;
  logic [7:0] data_out;
  logic       wen;

  logic [7:0] ram [256];
  logic [7:0] rd1;
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'h00;
  logic [7:0] pre_data = 8'h00;

  int wen_cnt = 0;
  int oe_cnt  = 0;
  int checks  = 0;
  int errors  = 0;

  typedef struct {
    logic [7:0]      cmd;
    logic [7:0]      adr;
    int              n;
    logic [2:0][7:0] d;
    int              exp_wen;
    logic            chk_addr;
    logic [7:0]      exp_addr;
    logic [2:0][7:0] exp_rd;
  } vec_t;

  vec_t vecs [5];

  qspi_ram_bridge #(.addr_width(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .qspi_sck    (qspi_sck),
    .qspi_cs_n   (qspi_cs_n),
    .qspi_io_in  (qspi_io_in),
    .qspi_io_out (qspi_io_out),
    .qspi_io_oe  (qspi_io_oe),
    .addr        (addr),
    .data_in     (ram_rdata),
    .data_out    (data_out),
    .wen         (wen)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (wen) ram[addr] <= data_out;
    rd1       <= ram[addr];
    ram_rdata <= rd1;
  end

  always @(posedge clk) begin
    if (wen) wen_cnt <= wen_cnt + 1;
    if (qspi_io_oe) oe_cnt <= oe_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic send_nibble(input logic [3:0] n);
    qspi_io_in = n;
    wait_clk(HALF);
    qspi_sck = 1'b1;
    wait_clk(HALF);
    qspi_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nibble(b[7:4]);
    send_nibble(b[3:0]);
  endtask

  task automatic read_nibble(output logic [3:0] n);
    wait_clk(HALF);
    qspi_sck = 1'b1;
    n = qspi_io_out;
    wait_clk(HALF);
    qspi_sck = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic [3:0] hi;
    logic [3:0] lo;
    read_nibble(hi);
    read_nibble(lo);
    b = {hi, lo};
  endtask

  task automatic cs_low();
    qspi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    qspi_cs_n = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic run_frame(input vec_t v, output logic [2:0][7:0] rd);
    logic [7:0] b;
    rd = '0;
    cs_low();
    send_byte(v.cmd);
    send_byte(v.adr);
    if (v.cmd == CMD_READ) begin
      send_byte(8'h00);
      for (int i = 0; i < v.n; i++) begin
        read_byte(b);
        rd[i] = b;
      end
    end else begin
      for (int i = 0; i < v.n; i++) send_byte(v.d[i]);
    end
    cs_high();
  endtask

  initial begin
    logic [2:0][7:0] rd;
    logic [7:0]      b;
    logic [7:0]      a;
    int              w0;
    int              o0;

    vecs[0] = '{cmd:8'h02, adr:8'h00, n:3, d:{8'h33, 8'h22, 8'h11}, exp_wen:3,
                chk_addr:1'b1, exp_addr:8'h03, exp_rd:'0};
    vecs[1] = '{cmd:8'h0B, adr:8'h10, n:3, d:'0, exp_wen:0,
                chk_addr:1'b0, exp_addr:8'h00, exp_rd:{8'h08, 8'h07, 8'h06}};
    vecs[2] = '{cmd:8'h02, adr:8'hFF, n:2, d:{8'h00, 8'hBB, 8'hAA}, exp_wen:2,
                chk_addr:1'b1, exp_addr:8'h01, exp_rd:'0};
    vecs[3] = '{cmd:8'h9F, adr:8'h12, n:3, d:{8'h78, 8'h56, 8'h34}, exp_wen:0,
                chk_addr:1'b0, exp_addr:8'h00, exp_rd:'0};
    vecs[4] = '{cmd:8'h0B, adr:8'hFE, n:2, d:'0, exp_wen:0,
                chk_addr:1'b0, exp_addr:8'h00, exp_rd:{8'h00, 8'hAA, 8'h3C}};

    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_wen", 32'(wen), 32'h0);
    chk("rst_io_out", 32'(qspi_io_out), 32'h0);
    chk("rst_io_oe", 32'(qspi_io_oe), 32'h0);

    preload(8'h10, 8'h06);
    preload(8'h11, 8'h07);
    preload(8'h12, 8'h08);
    preload(8'hFE, 8'h3C);
    preload(8'h05, 8'hE7);
    wait_clk(4);

    for (int k = 0; k < 5; k++) begin
      w0 = wen_cnt;
      o0 = oe_cnt;
      run_frame(vecs[k], rd);
      chk($sformatf("v%0d_wen_count", k), 32'(wen_cnt - w0), 32'(vecs[k].exp_wen));
      if (vecs[k].cmd == CMD_READ) begin
        chk($sformatf("v%0d_oe_seen", k), 32'(oe_cnt > o0), 32'h1);
        for (int i = 0; i < vecs[k].n; i++)
          chk($sformatf("v%0d_rd%0d", k, i), 32'(rd[i]), 32'(vecs[k].exp_rd[i]));
      end else if (vecs[k].exp_wen > 0) begin
        for (int i = 0; i < vecs[k].n; i++) begin
          a = vecs[k].adr + 8'(i);
          chk($sformatf("v%0d_ram%0d", k, i), 32'(ram[a]), 32'(vecs[k].d[i]));
        end
      end else begin
        chk($sformatf("v%0d_oe_quiet", k), 32'(oe_cnt - o0), 32'h0);
        chk($sformatf("v%0d_state_idle", k), 32'(dut.r_state), 32'(IDLE));
      end
      if (vecs[k].chk_addr)
        chk($sformatf("v%0d_addr_end", k), 32'(addr), 32'(vecs[k].exp_addr));
    end

    // Partial byte then CS rise: nothing written, next write is clean.
    w0 = wen_cnt;
    cs_low();
    send_byte(8'h02);
    send_byte(8'h05);
    send_nibble(4'hC);
    cs_high();
    chk("partial_no_wen", 32'(wen_cnt - w0), 32'h0);
    chk("partial_ram05", 32'(ram[8'h05]), 32'hE7);
    w0 = wen_cnt;
    run_frame('{cmd:8'h02, adr:8'h06, n:1, d:{8'h00, 8'h00, 8'h5A}, exp_wen:1,
                chk_addr:1'b1, exp_addr:8'h07, exp_rd:'0}, rd);
    chk("after_partial_wen", 32'(wen_cnt - w0), 32'h1);
    chk("after_partial_ram06", 32'(ram[8'h06]), 32'h5A);
    chk("after_partial_addr", 32'(addr), 32'h07);

    // Reset in the middle of a READ payload.
    cs_low();
    send_byte(8'h0B);
    send_byte(8'h10);
    send_byte(8'h00);
    read_byte(b);
    chk("midrd_byte0", 32'(b), 32'h06);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_addr", 32'(addr), 32'h0);
    chk("midrst_data_out", 32'(data_out), 32'h0);
    chk("midrst_wen", 32'(wen), 32'h0);
    chk("midrst_io_out", 32'(qspi_io_out), 32'h0);
    chk("midrst_io_oe", 32'(qspi_io_oe), 32'h0);
    rst = 1'b0;
    w0 = wen_cnt;
    o0 = oe_cnt;
    read_byte(b);
    cs_high();
    chk("postrst_oe_quiet", 32'(oe_cnt - o0), 32'h0);
    chk("postrst_no_wen", 32'(wen_cnt - w0), 32'h0);
    run_frame('{cmd:8'h0B, adr:8'h00, n:1, d:'0, exp_wen:0,
                chk_addr:1'b0, exp_addr:8'h00, exp_rd:'0}, rd);
    chk("postrst_rd00", 32'(rd[0]), 32'hBB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
